membus_arbiter: RTL and testbench

MEMBUS_ARBITER -- requirements
Module: membus_arbiter

---
 rtl/membus_arbiter_pkg.sv | 26 ++
 rtl/membus_arbiter_rr_select.sv | 38 +++
 rtl/membus_arbiter.sv | 129 ++++++++++++
 tb/tb_membus_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/membus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// membus_arbiter_pkg
// Shared definitions for the memory bus arbiter:
//   - default address/data widths
//   - arbitration mode encodings (fixed priority / round-robin)
//   - rr_next(): ring-walk helper over masters 1..n-1 (master 0 is never part
//     of the round-robin ring; it always wins outright)
// -----------------------------------------------------------------------------
package membus_arbiter_pkg;

  localparam int DEF_ADDR_WIDTH = 18;
  localparam int DEF_DATA_WIDTH = 32;

  localparam int RR_MODE_FIXED       = 0;
  localparam int RR_MODE_ROUND_ROBIN = 1;

  // Index reached by stepping 'step' places after 'ptr' on the ring 1..n-1.
  // For ptr in 1..n-1 and step in 1..n-1 the result always lies in 1..n-1.
  function automatic int rr_next(input int ptr, input int step, input int n);
    int idx;
    idx = ptr + step;
    if (idx > n - 1) idx = idx - (n - 1);
    return idx;
  endfunction

endpackage : membus_arbiter_pkg

// File: rtl/membus_arbiter_rr_select.sv
// -----------------------------------------------------------------------------
// rr_select
// Combinational round-robin picker over request bits 1..N-1.
//   req      : request vector (bit 0 is ignored; master 0 is handled by the top)
//   last_ptr : index of the most recently served ring master
//   gnt      : one-hot grant, first requester after last_ptr, wrapping N-1 -> 1;
//              all-zero when no ring master requests
// -----------------------------------------------------------------------------
module rr_select
  import membus_arbiter_pkg::*;
#(
  parameter int N     = 3,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] last_ptr,
  output logic [N-1:0]     gnt
);

  logic             found;
  logic [PTR_W-1:0] idx;

  // NOTE: every signal written in an always_comb gets a default on entry;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k < N; k++) begin
      idx = PTR_W'(rr_next(int'(last_ptr), k, N));
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule : rr_select

// File: rtl/membus_arbiter.sv
// -----------------------------------------------------------------------------
// membus_arbiter
// Arbitrates NUM_MASTERS memory bus masters onto one slave port.
// Master 0 (CPU path) always wins; otherwise fixed priority (lowest index) or
// round-robin over masters 1..N-1, selected by RR_MODE.
//
// Ports
//   clk, rst_n              : clock, synchronous active-low reset
//   m_strobe/m_write        : per-master request and direction (1 = write)
//   m_addr/m_wrdata/m_bytesel : packed per-master fields, master i in slice i
//   m_grant                 : one-hot combinational grant for this cycle
//   m_ack                   : one-cycle completion, RD_LATENCY after the grant
//   m_rddata                : s_rddata while any ack is set, else 0
//   s_strobe..s_bytesel     : granted master's fields, zero when idle
//   s_rddata                : slave read data, RD_LATENCY after s_strobe
// -----------------------------------------------------------------------------
module membus_arbiter
  import membus_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 3,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int RD_LATENCY  = 1,
  parameter int RR_MODE     = RR_MODE_ROUND_ROBIN,
  localparam int BSEL_WIDTH = DATA_WIDTH / 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_MASTERS-1:0]            m_strobe,
  input  logic [NUM_MASTERS-1:0]            m_write,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wrdata,
  input  logic [NUM_MASTERS*BSEL_WIDTH-1:0] m_bytesel,
  output logic [NUM_MASTERS-1:0]            m_grant,
  output logic [NUM_MASTERS-1:0]            m_ack,
  output logic [DATA_WIDTH-1:0]             m_rddata,
  output logic                              s_strobe,
  output logic                              s_write,
  output logic [ADDR_WIDTH-1:0]             s_addr,
  output logic [DATA_WIDTH-1:0]             s_wrdata,
  output logic [BSEL_WIDTH-1:0]             s_bytesel,
  input  logic [DATA_WIDTH-1:0]             s_rddata
);

  localparam int PTR_W = $clog2(NUM_MASTERS);

  logic [PTR_W-1:0]       last_rr_q, last_rr_d;
  logic [NUM_MASTERS-1:0] rr_gnt;
  logic [NUM_MASTERS-1:0] grant;
  logic [NUM_MASTERS-1:0] ack_pipe_q [RD_LATENCY];
  logic [NUM_MASTERS-1:0] ack_pipe_d [RD_LATENCY];

  rr_select #(
    .N     (NUM_MASTERS),
    .PTR_W (PTR_W)
  ) u_rr_select (
    .req      (m_strobe),
    .last_ptr (last_rr_q),
    .gnt      (rr_gnt)
  );

  // Grant: master 0 first, then the configured policy for the rest.
  always_comb begin : grant_logic
    grant = '0;
    if (m_strobe[0]) begin
      grant[0] = 1'b1;
    end else if (RR_MODE == RR_MODE_ROUND_ROBIN) begin
      grant = rr_gnt;
    end else begin
      // Walk downwards so the lowest requesting index is the last writer.
      for (int i = NUM_MASTERS - 1; i >= 1; i--) begin
        if (m_strobe[i]) grant = NUM_MASTERS'(1) << i;
      end
    end
  end

  assign m_grant  = grant;
  assign s_strobe = |grant;

  // Grant is one-hot, so at most one slice is routed; idle leaves zeros.
  always_comb begin : slave_mux
    s_write   = 1'b0;
    s_addr    = '0;
    s_wrdata  = '0;
    s_bytesel = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant[i]) begin
        s_write   = m_write[i];
        s_addr    = m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        s_wrdata  = m_wrdata[i*DATA_WIDTH +: DATA_WIDTH];
        s_bytesel = m_bytesel[i*BSEL_WIDTH +: BSEL_WIDTH];
      end
    end
  end

  // Only ring masters move the pointer; a master-0 grant leaves it alone.
  always_comb begin : last_rr_next
    last_rr_d = last_rr_q;
    for (int i = 1; i < NUM_MASTERS; i++) begin
      if (grant[i]) last_rr_d = PTR_W'(i);
    end
  end

  always_comb begin : ack_pipe_next
    ack_pipe_d[0] = grant;
    for (int s = 1; s < RD_LATENCY; s++) begin
      ack_pipe_d[s] = ack_pipe_q[s-1];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_rr_q <= PTR_W'(NUM_MASTERS - 1);
      // NOTE: the pipeline stages are reset explicitly; a grant left in flight
      // would otherwise surface as a late ack after reset is released.
      for (int s = 0; s < RD_LATENCY; s++) ack_pipe_q[s] <= '0;
    end else begin
      last_rr_q <= last_rr_d;
      for (int s = 0; s < RD_LATENCY; s++) ack_pipe_q[s] <= ack_pipe_d[s];
    end
  end

  // Masked during reset so acks read zero for the whole reset window.
  assign m_ack    = rst_n ? ack_pipe_q[RD_LATENCY-1] : '0;
  assign m_rddata = (|m_ack) ? s_rddata : '0;

endmodule : membus_arbiter

// File: tb/tb_membus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_membus_arbiter
// Three arbiter instances:
//   dut_a : N=3, round-robin, RD_LATENCY=1
//   dut_b : N=3, round-robin, RD_LATENCY=2 (same stimulus as dut_a)
//   dut_c : N=4, fixed priority, RD_LATENCY=1
// Expected grants come from hand-written tables or a bench model; expected
// acks are queued when a grant is expected and popped when they fall due.
// -----------------------------------------------------------------------------
module tb_membus_arbiter;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- N=3 group (dut_a, dut_b) ----------------
  logic [2:0]  strobe3 = '0, write3 = '0;
  logic [53:0] addr3 = '0;
  logic [95:0] wd3 = '0;
  logic [11:0] bs3 = '0;
  logic [31:0] srd = '0;

  logic [17:0] addr_m [3];
  logic [31:0] wd_m   [3];
  logic [3:0]  bs_m   [3];

  logic [2:0]  grant_a, ack_a, grant_b, ack_b;
  logic [31:0] rd_a, rd_b, swd_a, swd_b;
  logic        ss_a, sw_a, ss_b, sw_b;
  logic [17:0] sa_a, sa_b;
  logic [3:0]  sbs_a, sbs_b;

  // ---------------- N=4 group (dut_c) ----------------
  logic [3:0]   strobe4 = '0, write4 = '0;
  logic [71:0]  addr4 = '0;
  logic [127:0] wd4 = '0;
  logic [15:0]  bs4 = '1;
  logic [17:0]  addr4_m [4];

  logic [3:0]  grant_c, ack_c, sbs_c;
  logic [31:0] rd_c, swd_c;
  logic        ss_c, sw_c;
  logic [17:0] sa_c;

  membus_arbiter #(.NUM_MASTERS(3), .RD_LATENCY(1), .RR_MODE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .m_strobe(strobe3), .m_write(write3),
    .m_addr(addr3), .m_wrdata(wd3), .m_bytesel(bs3),
    .m_grant(grant_a), .m_ack(ack_a), .m_rddata(rd_a),
    .s_strobe(ss_a), .s_write(sw_a), .s_addr(sa_a), .s_wrdata(swd_a),
    .s_bytesel(sbs_a), .s_rddata(srd)
  );

  membus_arbiter #(.NUM_MASTERS(3), .RD_LATENCY(2), .RR_MODE(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .m_strobe(strobe3), .m_write(write3),
    .m_addr(addr3), .m_wrdata(wd3), .m_bytesel(bs3),
    .m_grant(grant_b), .m_ack(ack_b), .m_rddata(rd_b),
    .s_strobe(ss_b), .s_write(sw_b), .s_addr(sa_b), .s_wrdata(swd_b),
    .s_bytesel(sbs_b), .s_rddata(srd)
  );

  membus_arbiter #(.NUM_MASTERS(4), .RD_LATENCY(1), .RR_MODE(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .m_strobe(strobe4), .m_write(write4),
    .m_addr(addr4), .m_wrdata(wd4), .m_bytesel(bs4),
    .m_grant(grant_c), .m_ack(ack_c), .m_rddata(rd_c),
    .s_strobe(ss_c), .s_write(sw_c), .s_addr(sa_c), .s_wrdata(swd_c),
    .s_bytesel(sbs_c), .s_rddata(srd)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int mdl_last = 2;   // bench copy of the round-robin pointer

  typedef struct {
    int         due;
    logic [2:0] ack;
  } sb_entry_t;

  sb_entry_t qa[$];
  sb_entry_t qb[$];

  typedef struct {
    logic       rst;
    logic [2:0] strobe;
    logic [2:0] exp;
  } rr_vec_t;

  typedef struct {
    logic [3:0] strobe;
    logic [3:0] exp;
  } fp_vec_t;

  rr_vec_t rr_tab[$];
  fp_vec_t fp_tab[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
  endtask

  // Independent round-robin model: ring 1..2 after 'last', master 0 overrides.
  function automatic logic [2:0] rr_model(input logic [2:0] req, input int last);
    if (req[0]) return 3'b001;
    for (int k = 1; k <= 2; k++) begin
      int idx;
      idx = ((last - 1 + k) % 2) + 1;
      if (req[idx]) return 3'(1 << idx);
    end
    return 3'b000;
  endfunction

  function automatic logic [63:0] exp_fields(input logic [2:0] g, input logic [2:0] wr);
    logic [63:0] f;
    f = '0;
    for (int i = 0; i < 3; i++) begin
      if (g[i]) f = {8'h00, 1'b1, wr[i], bs_m[i], wd_m[i], addr_m[i]};
    end
    return f;
  endfunction

  // One clock cycle of the N=3 group: drive, check at negedge, advance.
  task automatic cyc_rr(input logic rst_v, input logic [2:0] strobe,
                        input logic [2:0] wr, input logic [31:0] srd_v,
                        input logic [2:0] exp_grant);
    logic [2:0] exp_a, exp_b;
    rst_n   = rst_v;
    strobe3 = strobe;
    write3  = wr;
    srd     = srd_v;
    for (int i = 0; i < 3; i++) begin
      addr3[i*18 +: 18] = addr_m[i];
      wd3[i*32 +: 32]   = wd_m[i];
      bs3[i*4 +: 4]     = bs_m[i];
    end
    @(negedge clk);
    check("grant_a", 64'(grant_a), 64'(exp_grant));
    check("grant_b", 64'(grant_b), 64'(exp_grant));
    check("s_fields_a", {8'h00, ss_a, sw_a, sbs_a, swd_a, sa_a}, exp_fields(exp_grant, wr));
    exp_a = '0;
    exp_b = '0;
    if (rst_v && qa.size() > 0 && qa[0].due == cyc) exp_a = qa.pop_front().ack;
    if (rst_v && qb.size() > 0 && qb[0].due == cyc) exp_b = qb.pop_front().ack;
    check("ack_a", 64'(ack_a), 64'(exp_a));
    check("rddata_a", 64'(rd_a), (exp_a != 0) ? 64'(srd_v) : 64'h0);
    check("ack_b", 64'(ack_b), 64'(exp_b));
    check("rddata_b", 64'(rd_b), (exp_b != 0) ? 64'(srd_v) : 64'h0);
    if (!rst_v) begin
      qa.delete();
      qb.delete();
      mdl_last = 2;
    end else if (exp_grant != 0) begin
      qa.push_back('{cyc + 1, exp_grant});
      qb.push_back('{cyc + 2, exp_grant});
      if (exp_grant[2]) mdl_last = 2;
      else if (exp_grant[1]) mdl_last = 1;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    logic [3:0] prev_c;

    for (int i = 0; i < 3; i++) begin
      addr_m[i] = 18'h00200 + 18'(i * 16);
      wd_m[i]   = 32'h1111_0000 + 32'(i);
      bs_m[i]   = 4'(i + 5);
    end
    for (int i = 0; i < 4; i++) begin
      addr4_m[i]         = 18'h01000 + 18'(i * 64);
      addr4[i*18 +: 18]  = addr4_m[i];
      wd4[i*32 +: 32]    = 32'hC0DE_0000 + 32'(i);
    end

    // Establish a known post-reset state before the checked cycles.
    repeat (2) @(posedge clk);
    #1;

    // ---------- round-robin table (dut_a / dut_b) ----------
    rr_tab.push_back('{1'b0, 3'b000, 3'b000});  // reset: acks/rddata zero
    rr_tab.push_back('{1'b0, 3'b110, 3'b010});  // grant stays combinational in reset
    rr_tab.push_back('{1'b1, 3'b110, 3'b010});  // held 110 -> 1,2,1,2
    rr_tab.push_back('{1'b1, 3'b110, 3'b100});
    rr_tab.push_back('{1'b1, 3'b110, 3'b010});
    rr_tab.push_back('{1'b1, 3'b110, 3'b100});
    rr_tab.push_back('{1'b1, 3'b010, 3'b010});  // pointer now at 1
    rr_tab.push_back('{1'b1, 3'b111, 3'b001});  // master 0 always wins
    rr_tab.push_back('{1'b1, 3'b111, 3'b001});
    rr_tab.push_back('{1'b1, 3'b111, 3'b001});
    rr_tab.push_back('{1'b1, 3'b110, 3'b100});  // pointer untouched by master 0
    rr_tab.push_back('{1'b1, 3'b000, 3'b000});
    rr_tab.push_back('{1'b1, 3'b100, 3'b100});
    rr_tab.push_back('{1'b1, 3'b101, 3'b001});
    rr_tab.push_back('{1'b1, 3'b110, 3'b010});
    rr_tab.push_back('{1'b1, 3'b110, 3'b100});  // master 1 re-requests, ranks last
    rr_tab.push_back('{1'b1, 3'b000, 3'b000});
    rr_tab.push_back('{1'b1, 3'b000, 3'b000});
    foreach (rr_tab[k]) begin
      cyc_rr(rr_tab[k].rst, rr_tab[k].strobe, 3'(k), 32'hA000_0000 | 32'(k), rr_tab[k].exp);
    end

    // ---------- read through the RD_LATENCY=2 instance ----------
    addr_m[1] = 18'h00104;
    cyc_rr(1'b1, 3'b010, 3'b000, 32'h0000_0000, 3'b010);
    cyc_rr(1'b1, 3'b000, 3'b000, 32'h1234_5678, 3'b000);  // dut_a ack here
    cyc_rr(1'b1, 3'b000, 3'b000, 32'hDEAD_BEEF, 3'b000);  // dut_b ack here
    cyc_rr(1'b1, 3'b000, 3'b000, 32'hDEAD_BEEF, 3'b000);  // no repeat

    // ---------- reset in the cycle after a grant ----------
    cyc_rr(1'b1, 3'b010, 3'b000, 32'h5555_0000, 3'b010);  // pointer -> 1
    cyc_rr(1'b0, 3'b000, 3'b000, 32'h5555_0001, 3'b000);
    cyc_rr(1'b1, 3'b000, 3'b000, 32'h5555_0002, 3'b000);  // no late ack
    cyc_rr(1'b1, 3'b000, 3'b000, 32'h5555_0003, 3'b000);
    cyc_rr(1'b1, 3'b110, 3'b000, 32'h5555_0004, 3'b010);  // master 1 first again
    cyc_rr(1'b1, 3'b000, 3'b000, 32'h5555_0005, 3'b000);
    cyc_rr(1'b1, 3'b000, 3'b000, 32'h5555_0006, 3'b000);

    // ---------- random multi-master run against the model ----------
    for (int k = 0; k < 300; k++) begin
      logic [2:0] st, wr;
      st = 3'($urandom_range(0, 7));
      wr = 3'($urandom);
      for (int i = 0; i < 3; i++) begin
        addr_m[i] = 18'($urandom);
        wd_m[i]   = $urandom;
        bs_m[i]   = 4'($urandom);
      end
      cyc_rr(1'b1, st, wr, $urandom, rr_model(st, mdl_last));
    end
    repeat (3) cyc_rr(1'b1, 3'b000, 3'b000, $urandom, 3'b000);
    check("sb_drained_a", 64'(qa.size()), 64'h0);
    check("sb_drained_b", 64'(qb.size()), 64'h0);

    // ---------- fixed-priority table (dut_c) ----------
    fp_tab = '{
      '{4'b0000, 4'b0000},
      '{4'b1100, 4'b0100},   // master 2 wins, its address routed
      '{4'b1010, 4'b0010},
      '{4'b1001, 4'b0001},
      '{4'b1000, 4'b1000},
      '{4'b0110, 4'b0010},
      '{4'b1111, 4'b0001},
      '{4'b0000, 4'b0000},
      '{4'b0000, 4'b0000}
    };
    strobe3 = '0;
    prev_c  = '0;
    foreach (fp_tab[k]) begin
      logic [17:0] exp_addr;
      strobe4  = fp_tab[k].strobe;
      srd      = 32'hC0FF_EE00 + 32'(k);
      exp_addr = '0;
      for (int i = 0; i < 4; i++) if (fp_tab[k].exp[i]) exp_addr = addr4_m[i];
      @(negedge clk);
      check("grant_c", 64'(grant_c), 64'(fp_tab[k].exp));
      check("s_strobe_c", 64'(ss_c), 64'(fp_tab[k].exp != 0));
      check("s_addr_c", 64'(sa_c), 64'(exp_addr));
      check("ack_c", 64'(ack_c), 64'(prev_c));
      check("rddata_c", 64'(rd_c), (prev_c != 0) ? 64'(srd) : 64'h0);
      prev_c = fp_tab[k].exp;
      @(posedge clk);
      #1;
      cyc++;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_membus_arbiter
